// File: rtl/pwm_result_unloader_if.sv
// Stream/BRAM signal bundle for the PWM result unloader.
// master is the unloader side; slave is the host + result BRAM side.
interface pwm_result_unloader_if #(
   parameter int LOGQ = 54,
   parameter int LOGN = 13
);
   logic            start;
   logic [LOGN-1:0] bram_rd_addr;
   logic [LOGQ-1:0] bram0_rd_data;
   logic [LOGQ-1:0] bram1_rd_data;
   logic [LOGQ-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic            busy;
   logic            done;
   logic            mismatch;

   modport master (
      input  start, bram0_rd_data, bram1_rd_data, out_ready,
      output bram_rd_addr, out_data, out_valid, out_last, busy, done, mismatch
   );

   modport slave (
      output start, bram0_rd_data, bram1_rd_data, out_ready,
      input  bram_rd_addr, out_data, out_valid, out_last, busy, done, mismatch
   );
endinterface

// File: rtl/pwm_result_unloader.sv
// Streams N coefficients out of the duplicated result BRAMs through a credit-controlled
// FWFT buffer, flagging any disagreement between the two copies.
module pwm_result_unloader #(
   parameter int LOGQ       = 54,
   parameter int LOGN       = 13,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   pwm_result_unloader_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int IW = $clog2(RD_LAT + 1);

   if (FIFO_DEPTH < RD_LAT + 2) begin : g_depth_check
      $error("pwm_result_unloader: FIFO_DEPTH must be >= RD_LAT+2");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t          state_q;
   logic [LOGN-1:0] cnt_q;
   logic [LOGN-1:0] addr_q;
   logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
   logic [RD_LAT-1:0] rd_last_q, rd_last_d;
   logic [IW-1:0]   infl_cnt_q, infl_cnt_d;
   logic [LOGQ-1:0] fifo_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic            busy_q, done_q, mismatch_q;

   logic accept, credit, issue, push, push_last, pop, head_last, out_vld;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   // Credit counts both buffered entries and reads still in the BRAM pipeline
   always_comb begin
      accept     = (state_q == S_IDLE) && bus.start;
      credit     = (int'(fifo_cnt_q) + int'(infl_cnt_q)) < FIFO_DEPTH;
      issue      = credit && (accept || (state_q == S_READ));
      push       = rd_vld_q[RD_LAT-1];
      push_last  = rd_last_q[RD_LAT-1];
      out_vld    = (fifo_cnt_q != '0);
      pop        = out_vld && bus.out_ready;
      head_last  = fifo_last_q[rd_ptr_q];
      rd_vld_d   = '0;
      rd_last_d  = '0;
      rd_vld_d[0]  = issue;
      rd_last_d[0] = issue && (&cnt_q);
      for (int i = 1; i < RD_LAT; i++) begin
         rd_vld_d[i]  = rd_vld_q[i-1];
         rd_last_d[i] = rd_last_q[i-1];
      end
      infl_cnt_d = infl_cnt_q + IW'(issue) - IW'(push);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rd_vld_q   <= '0;
         rd_last_q  <= '0;
         infl_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         rd_vld_q   <= rd_vld_d;
         rd_last_q  <= rd_last_d;
         infl_cnt_q <= infl_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         done_q     <= 1'b0;
         if (issue) begin
            addr_q <= cnt_q;
            cnt_q  <= cnt_q + LOGN'(1);
         end
         if (push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (bus.bram0_rd_data != bus.bram1_rd_data) mismatch_q <= 1'b1;
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q    <= S_READ;
                  busy_q     <= 1'b1;
                  mismatch_q <= 1'b0;
               end
            end
            S_READ: begin
               if (issue && (&cnt_q)) begin
                  state_q <= S_DRAIN;
                  cnt_q   <= '0;
               end
            end
            S_DRAIN: begin
               if (pop && head_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Buffer storage holds data only; occupancy is tracked by the control registers
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= bus.bram0_rd_data;
         fifo_last_q[wr_ptr_q] <= push_last;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && (int'(fifo_cnt_q) == FIFO_DEPTH)));

   assign bus.bram_rd_addr = addr_q;
   assign bus.out_valid    = out_vld;
   assign bus.out_data     = out_vld ? fifo_data_q[rd_ptr_q] : '0;
   assign bus.out_last     = out_vld && head_last;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.mismatch     = mismatch_q;
endmodule

// File: tb/tb_pwm_result_unloader.sv
// Directed bench for pwm_result_unloader: ramp, backpressure, copy mismatch,
// mid-unload reset, start-while-busy and an RD_LAT=3 instance.
module tb_pwm_result_unloader;
   logic clk;
   logic rst;
   logic start_r, ready_r, dut_sel, corrupt_en;
   int   pat_r;
   int   n_chk, n_pass, n_fail;

   pwm_result_unloader_if #(.LOGQ(54), .LOGN(13)) if0 ();
   pwm_result_unloader_if #(.LOGQ(54), .LOGN(10)) if3 ();

   pwm_result_unloader #(.LOGQ(54), .LOGN(13), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .bus(if0));
   pwm_result_unloader #(.LOGQ(54), .LOGN(10), .RD_LAT(3), .FIFO_DEPTH(5)) u_dut3 (
      .clk(clk), .rst(rst), .bus(if3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [53:0] pat_val(input int pat, input int idx);
      logic [53:0] v;
      v = 54'(idx) * 54'd3;
      return (pat != 0) ? ~v : v;
   endfunction

   // BRAM models: RD_LAT-1 address registers followed by a combinational lookup
   logic [12:0] a0_d1;
   logic [9:0]  a3_d1, a3_d2;
   always_ff @(posedge clk) begin
      a0_d1 <= if0.bram_rd_addr;
      a3_d1 <= if3.bram_rd_addr;
      a3_d2 <= a3_d1;
   end
   assign if0.bram0_rd_data = pat_val(pat_r, int'(a0_d1));
   assign if0.bram1_rd_data = pat_val(pat_r, int'(a0_d1)) ^
                              ((corrupt_en && a0_d1 == 13'd5000) ? 54'd1 : 54'd0);
   assign if3.bram0_rd_data = pat_val(pat_r, int'(a3_d2));
   assign if3.bram1_rd_data = pat_val(pat_r, int'(a3_d2));
   assign if0.start     = start_r & ~dut_sel;
   assign if3.start     = start_r & dut_sel;
   assign if0.out_ready = ready_r & ~dut_sel;
   assign if3.out_ready = ready_r & dut_sel;

   logic [53:0] m_data;
   logic        m_valid, m_last, m_busy, m_done, m_mm;
   int          m_addr;
   assign m_data  = dut_sel ? if3.out_data  : if0.out_data;
   assign m_valid = dut_sel ? if3.out_valid : if0.out_valid;
   assign m_last  = dut_sel ? if3.out_last  : if0.out_last;
   assign m_busy  = dut_sel ? if3.busy      : if0.busy;
   assign m_done  = dut_sel ? if3.done      : if0.done;
   assign m_mm    = dut_sel ? if3.mismatch  : if0.mismatch;
   assign m_addr  = dut_sel ? int'(if3.bram_rd_addr) : int'(if0.bram_rd_addr);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},  64'(if0.bram_rd_addr), 64'd0);
      chk({tag, "_data"},  64'(if0.out_data),     64'd0);
      chk({tag, "_valid"}, 64'(if0.out_valid),    64'd0);
      chk({tag, "_last"},  64'(if0.out_last),     64'd0);
      chk({tag, "_busy"},  64'(if0.busy),         64'd0);
      chk({tag, "_done"},  64'(if0.done),         64'd0);
      chk({tag, "_mm"},    64'(if0.mismatch),     64'd0);
   endtask

   // One complete unload; all observation happens at the falling edge, c counts edges after E0
   task automatic run_unload(input string tag, input int n, input int rdlat, input int depth,
                             input int pct, input bit full, input int mm_idx, input bit drain_pulse);
      int c, hs, first_v, last_hs_c, done_c, done_cnt, budget, outst, max_out;
      int data_err, last_err, stab_err, busy_err;
      bit stalled, pulsed;
      logic [53:0] pdata;
      logic        plast;
      c = 0; hs = 0; first_v = -1; last_hs_c = -1; done_c = -1; done_cnt = 0; max_out = 0;
      data_err = 0; last_err = 0; stab_err = 0; busy_err = 0; stalled = 0; pulsed = 0;
      pdata = '0; plast = 1'b0;
      budget = n * 5 + 50;
      @(negedge clk);
      start_r = 1'b1;
      ready_r = ($urandom_range(99) < pct);
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0;
      chk({tag, "_mm_clear"}, 64'(m_mm), 64'd0);
      while (c <= budget) begin
         if (m_done) begin
            done_cnt++;
            if (done_c < 0) begin
               done_c = c;
               chk({tag, "_busy_at_done"}, 64'(m_busy), 64'd0);
               chk({tag, "_mm_at_done"}, 64'(m_mm), 64'(mm_idx >= 0));
            end
         end else if (done_c < 0 && !m_busy) busy_err++;
         if (first_v < 0 && m_valid) first_v = c;
         if (stalled && (!m_valid || m_data !== pdata || m_last !== plast)) stab_err++;
         if (done_c < 0) begin
            outst = m_addr + 1 - hs;
            if (outst > max_out) max_out = outst;
         end
         if (mm_idx >= 0 && c == rdlat + mm_idx - 1) chk({tag, "_mm_before"}, 64'(m_mm), 64'd0);
         if (mm_idx >= 0 && c == rdlat + mm_idx)     chk({tag, "_mm_rise"},   64'(m_mm), 64'd1);
         start_r = 1'b0;
         if (drain_pulse && !pulsed && hs == n - 2) begin
            start_r = 1'b1;
            pulsed  = 1'b1;
         end
         ready_r = ($urandom_range(99) < pct);
         if (m_valid && ready_r) begin
            if (m_data !== pat_val(pat_r, hs)) data_err++;
            if (m_last !== (hs == n - 1)) last_err++;
            last_hs_c = c;
            hs++;
         end
         stalled = m_valid && !ready_r;
         pdata   = m_data;
         plast   = m_last;
         if (done_c >= 0 && c >= done_c + 3) break;
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      start_r = 1'b0;
      ready_r = 1'b1;
      chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'd1);
      chk({tag, "_count"}, 64'(hs), 64'(n));
      chk({tag, "_data_err"}, 64'(data_err), 64'd0);
      chk({tag, "_last_err"}, 64'(last_err), 64'd0);
      chk({tag, "_stable_err"}, 64'(stab_err), 64'd0);
      chk({tag, "_busy_err"}, 64'(busy_err), 64'd0);
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, "_credit_ok"}, 64'(max_out <= depth), 64'd1);
      chk({tag, "_first_valid"}, 64'(first_v), 64'(rdlat));
      chk({tag, "_idle_after"}, 64'(m_busy), 64'd0);
      chk({tag, "_mm_after"}, 64'(m_mm), 64'(mm_idx >= 0));
      if (full) begin
         chk({tag, "_last_hs_edge"}, 64'(last_hs_c), 64'(rdlat + n - 1));
         chk({tag, "_done_edge"}, 64'(done_c), 64'(rdlat + n));
      end
   endtask

   task automatic reset_mid();
      int hs, c, spur;
      hs = 0; c = 0; spur = 0;
      @(negedge clk);
      start_r = 1'b1;
      ready_r = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0;
      while (hs < 1000 && c < 5000) begin
         if (m_valid && ready_r) hs++;
         if (hs == 1000) ready_r = 1'b0;
         @(posedge clk);
         @(negedge clk);
         c++;
      end
      chk("rstmid_hs", 64'(hs), 64'd1000);
      repeat (9) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("rstmid_pre_valid", 64'(m_valid), 64'd1);
      chk("rstmid_pre_busy", 64'(m_busy), 64'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      ready_r = 1'b1;
      chk_reset_vals("rstmid");
      repeat (6) begin
         @(posedge clk);
         @(negedge clk);
         if (m_valid || m_busy) spur++;
      end
      chk("rstmid_spurious", 64'(spur), 64'd0);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0;
      rst = 1'b0; start_r = 1'b0; ready_r = 1'b1; dut_sel = 1'b0;
      corrupt_en = 1'b0; pat_r = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b1;
      repeat (2) @(posedge clk);

      run_unload("ramp", 8192, 2, 4, 100, 1'b1, -1, 1'b0);
      run_unload("bp30", 8192, 2, 4, 30, 1'b0, -1, 1'b0);
      corrupt_en = 1'b1;
      run_unload("copy_bad", 8192, 2, 4, 100, 1'b1, 5000, 1'b0);
      corrupt_en = 1'b0;
      run_unload("copy_clean", 8192, 2, 4, 100, 1'b1, -1, 1'b0);
      reset_mid();
      pat_r = 1;
      run_unload("fresh_drain_start", 8192, 2, 4, 100, 1'b1, -1, 1'b1);
      dut_sel = 1'b1;
      run_unload("lat3", 1024, 3, 5, 100, 1'b1, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pwm_result_unloader.md
# pwm_result_unloader

Streams a completed pointwise-multiplication result out of the duplicated result BRAM pair (`result0` / `result1`) after the PWM unit signals done. It reads coefficients 0..N-1 in order and presents them on a valid/ready stream with backpressure, in place of the host's manual address-and-wait readback. It also checks that both BRAM copies agree and raises a sticky flag on any disagreement.

## Interface
- `LOGQ`, 54, coefficient width
- `LOGN`, 13, log2 of coefficient count; N = 2^LOGN
- `RD_LAT`, 2, BRAM read latency in cycles, from address register update to data valid (≥1)
- `FIFO_DEPTH`, 4, output buffer entries; must be ≥ RD_LAT+2 (elaboration-time check)

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  begin unload; sampled only in IDLE
- `bram_rd_addr`  out  LOGN  registered read address to both result BRAMs
- `bram0_rd_data`  in  LOGQ  read data, result0 copy
- `bram1_rd_data`  in  LOGQ  read data, result1 copy
- `out_data`  out  LOGQ  coefficient at FIFO head (taken from copy 0)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts on `out_valid && out_ready`
- `out_last`  out  1  high with coefficient N-1
- `busy`  out  1  high from the start-sampling edge until `done`
- `done`  out  1  one-cycle pulse after the final handshake
- `mismatch`  out  1  sticky: some coefficient had copy0 ≠ copy1; cleared on accepted start

## Operation
- FSM: IDLE → READ on `start`; READ → DRAIN once address N-1 is issued; DRAIN → IDLE on the handshake of coefficient N-1 (this handshake also fires `done`).
- Issue rule: in READ, address `cnt` is issued at an edge iff `fifo_count + inflight < FIFO_DEPTH`. Issuing sets `bram_rd_addr <= cnt` and `cnt <= cnt+1`. The accepted start edge issues address 0 when credit permits, which is always true from empty.
- `inflight` is an RD_LAT-deep shift register of issue markers. A marker reaching the end means the data is sampled at that edge and pushed into the FIFO.
- On push, `bram0_rd_data` is compared with `bram1_rd_data`. Any inequality sets `mismatch`, which stays set until the next accepted start or reset.
- FIFO is first-word-fall-through. Simultaneous push and pop at any fill level is legal. The credit rule makes overflow impossible; overflow is an assertion error.
- `out_last` is stored per entry (address == N-1) and travels with its data.
- `start` while busy is ignored. `out_ready` while `out_valid` = 0 is ignored.
- Address counter: LOGN-bit, no wrap. READ stops issuing after N-1.
- Reset (any state, mid-unload included): FSM → IDLE, FIFO emptied, inflight cleared, `cnt` = 0. Stale BRAM data arriving afterwards is discarded.
- Reset values: `bram_rd_addr` = 0, `out_data` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `done` = 0, `mismatch` = 0.

## Timing
- Accepted start at edge E0 issues address 0. Its data is pushed at E0+RD_LAT, and `out_valid` rises after that edge.
- With `out_ready` held high and FIFO_DEPTH ≥ RD_LAT+2, throughput is one coefficient per cycle with no bubbles.
  - Handshakes occur at edges E0+RD_LAT+1 … E0+RD_LAT+N.
  - `done` is high for the single cycle after edge E0+RD_LAT+N.
  - `busy` falls at that same edge.
- Backpressure: at most FIFO_DEPTH coefficients are outstanding (buffered plus inflight). Issue resumes on the edge after credit frees.
- `out_data`, `out_valid` and `out_last` stay stable while `out_valid && !out_ready`.
- A new start is accepted no earlier than the cycle in which `done` is high (FSM is already IDLE).

## Test plan
- **Ramp, no backpressure:** result0 = result1 = i·3 mod 2^54, RD_LAT = 2, `out_ready` = 1.
  - Required: 8192 handshakes at consecutive edges E0+3 … E0+8194, data = i·3 in order.
  - `out_last` only on i = 8191; `done` one cycle; `mismatch` = 0.
- **Random backpressure:** `out_ready` random at 30% duty.
  - Required: identical ordered data; `out_data` stable during stalls.
  - `fifo_count + inflight` ≤ 4 every cycle; no dropped or duplicated coefficient.
- **Copy disagreement:** result1[5000] = result0[5000] ^ 1.
  - Required: `mismatch` rises right after the push edge of coefficient 5000 and stays high through `done`.
  - Stream data equals copy 0; a second start clears `mismatch` and the rerun with clean data ends at 0.
- **Reset mid-unload:** `rst` = 0 for one cycle after 1000 handshakes with `out_ready` = 0 for the last 10 cycles.
  - Required: next cycle all outputs at reset values, no spurious `out_valid`.
  - A fresh start streams from coefficient 0.
- **Start while busy, and RD_LAT = 3 variant:** pulse `start` during DRAIN.
  - Required: ignored, exactly N coefficients, single `done`.
  - With RD_LAT = 3 and FIFO_DEPTH = 5: first `out_valid` after E0+3, full throughput.
